// File: rtl/gpa_fhdo_pkg.sv
// Shared constants for the GPA-FHDO DAC80504 SPI model: frame layout, register map, FSM states.
package gpa_fhdo_pkg;
    localparam int FRAME_BITS = 24;
    localparam int RW_BIT     = 23;
    localparam int ADDR_MSB   = 19;
    localparam int ADDR_LSB   = 16;
    localparam int DATA_MSB   = 15;
    localparam int DATA_LSB   = 0;
    localparam int LDAC_BIT   = 4;
    localparam int NUM_CH     = 4;

    localparam logic [3:0] ADDR_ID      = 4'h1;
    localparam logic [3:0] ADDR_SYNC    = 4'h2;
    localparam logic [3:0] ADDR_TRIGGER = 4'h5;
    localparam logic [3:0] ADDR_BRDCAST = 4'h6;
    localparam logic [3:0] ADDR_DAC0    = 4'h8;
    localparam logic [3:0] ADDR_DAC1    = 4'h9;
    localparam logic [3:0] ADDR_DAC2    = 4'hA;
    localparam logic [3:0] ADDR_DAC3    = 4'hB;

    localparam logic [15:0] SYNC_RST        = 16'hFF00;
    localparam logic [15:0] SOFT_RESET_CODE = 16'h000A;

    typedef enum logic [1:0] {ST_ARM, ST_IDLE, ST_SHIFT, ST_COMMIT} state_t;
endpackage

// File: rtl/gpa_fhdo_dac_spi_slave_spi_pin_sync.sv
// Multi-flop synchroniser for one SPI pin with registered-history rise/fall detection.
module spi_pin_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], pin};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;
endmodule

// File: rtl/gpa_fhdo_dac_spi_slave.sv
// DAC80504 SPI responder model: decodes 24-bit frames into SYNC/BRDCAST/DAC registers.
// Define GPA_FHDO_SLAVE_READBACK_EN to enable register readback on spi_sdo_o.
module gpa_fhdo_dac_spi_slave
    import gpa_fhdo_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] DEVICE_ID   = 16'h0300
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_clk_i,
    input  logic        spi_csn_i,
    input  logic        spi_sdi_i,
    output logic        spi_sdo_o,
    output logic [63:0] dac_data_o,
    output logic [3:0]  dac_update_o,
    output logic [15:0] sync_reg_o,
    output logic        frame_valid_o,
    output logic        frame_err_o,
    output logic [23:0] frame_word_o
);
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic csn_lvl, csn_rise, csn_fall;
    logic sdi_lvl, sdi_rise, sdi_fall;

    // CSN chain resets low so a pin already high at release shows up as a rise (leaves ARM).
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk (
        .clk(clk), .rst_n(rst_n), .pin(spi_clk_i), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_csn (
        .clk(clk), .rst_n(rst_n), .pin(spi_csn_i), .level(csn_lvl), .rise(csn_rise), .fall(csn_fall));
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdi (
        .clk(clk), .rst_n(rst_n), .pin(spi_sdi_i), .level(sdi_lvl), .rise(sdi_rise), .fall(sdi_fall));

    state_t                    state;
    logic [4:0]                cnt;
    logic [FRAME_BITS-1:0]     sr;
    logic                      pend;
    logic [15:0]               sync_q, bcast_q;
    logic [NUM_CH-1:0][15:0]   buf_q, dac_q;

    logic [NUM_CH-1:0][15:0]   buf_n, dac_n;
    logic [15:0]               sync_n, bcast_n;
    logic [NUM_CH-1:0]         upd_n;

    wire        is_rd   = sr[RW_BIT];
    wire [3:0]  addr    = sr[ADDR_MSB:ADDR_LSB];
    wire [15:0] data    = sr[DATA_MSB:DATA_LSB];
    wire        soft_rst = !is_rd && addr == ADDR_TRIGGER && data == SOFT_RESET_CODE;

    always_comb begin
        sync_n  = sync_q;
        bcast_n = bcast_q;
        buf_n   = buf_q;
        dac_n   = dac_q;
        upd_n   = '0;
        if (!is_rd) begin
            case (addr)
                ADDR_SYNC: sync_n = data;
                ADDR_TRIGGER:
                    if (data[LDAC_BIT])
                        for (int ch = 0; ch < NUM_CH; ch++)
                            if (sync_q[ch]) dac_n[ch] = buf_q[ch];
                ADDR_BRDCAST: begin
                    bcast_n = data;
                    for (int ch = 0; ch < NUM_CH; ch++)
                        if (sync_q[8+ch]) begin
                            buf_n[ch] = data;
                            if (!sync_q[ch]) dac_n[ch] = data;
                        end
                end
                ADDR_DAC0, ADDR_DAC1, ADDR_DAC2, ADDR_DAC3: begin
                    buf_n[addr[1:0]] = data;
                    if (!sync_q[addr[1:0]]) dac_n[addr[1:0]] = data;
                end
                default: ;
            endcase
        end
        for (int ch = 0; ch < NUM_CH; ch++)
            upd_n[ch] = dac_n[ch] != dac_q[ch];
    end

`ifdef GPA_FHDO_SLAVE_READBACK_EN
    logic [FRAME_BITS-1:0] rd_word, sdo_sr;
    logic                  sdo;
    logic [15:0]           rd_val;

    always_comb begin
        case (addr)
            ADDR_ID:      rd_val = DEVICE_ID;
            ADDR_SYNC:    rd_val = sync_q;
            ADDR_BRDCAST: rd_val = bcast_q;
            ADDR_DAC0, ADDR_DAC1, ADDR_DAC2, ADDR_DAC3: rd_val = dac_q[addr[1:0]];
            default:      rd_val = 16'h0000;
        endcase
    end

    assign spi_sdo_o = sdo;
    logic unused_pins;
    assign unused_pins = ^{sdi_rise, sdi_fall, sclk_lvl};
`else
    assign spi_sdo_o = 1'b0;
    logic unused_pins;
    assign unused_pins = ^{sdi_rise, sdi_fall, sclk_lvl, sclk_rise, DEVICE_ID};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_ARM;
            cnt           <= '0;
            sr            <= '0;
            pend          <= 1'b0;
            sync_q        <= SYNC_RST;
            bcast_q       <= '0;
            buf_q         <= '0;
            dac_q         <= '0;
            dac_update_o  <= '0;
            frame_valid_o <= 1'b0;
            frame_err_o   <= 1'b0;
            frame_word_o  <= '0;
`ifdef GPA_FHDO_SLAVE_READBACK_EN
            rd_word       <= '0;
            sdo_sr        <= '0;
            sdo           <= 1'b0;
`endif
        end else begin
            frame_valid_o <= 1'b0;
            frame_err_o   <= 1'b0;
            dac_update_o  <= '0;
            case (state)
                ST_ARM: if (csn_lvl) state <= ST_IDLE;
                ST_IDLE:
                    if (csn_fall || pend) begin
                        state <= ST_SHIFT;
                        cnt   <= '0;
                        pend  <= 1'b0;
`ifdef GPA_FHDO_SLAVE_READBACK_EN
                        sdo_sr <= rd_word;
                        sdo    <= rd_word[FRAME_BITS-1];
`endif
                    end
                ST_SHIFT: begin
                    if (csn_rise) begin
                        state <= ST_COMMIT;
`ifdef GPA_FHDO_SLAVE_READBACK_EN
                        sdo   <= 1'b0;
`endif
                    end else begin
                        if (sclk_fall) begin
                            sr <= {sr[FRAME_BITS-2:0], sdi_lvl};
                            if (cnt < 5'd25) cnt <= cnt + 5'd1;
                        end
`ifdef GPA_FHDO_SLAVE_READBACK_EN
                        if (sclk_rise) begin
                            sdo_sr <= {sdo_sr[FRAME_BITS-2:0], 1'b0};
                            sdo    <= sdo_sr[FRAME_BITS-2];
                        end
`endif
                    end
                end
                ST_COMMIT: begin
                    state <= ST_IDLE;
                    if (csn_fall) pend <= 1'b1;
                    if (cnt == 5'(FRAME_BITS)) begin
                        frame_valid_o <= 1'b1;
                        frame_word_o  <= sr;
                        if (soft_rst) begin
                            sync_q  <= SYNC_RST;
                            bcast_q <= '0;
                            buf_q   <= '0;
                            dac_q   <= '0;
`ifdef GPA_FHDO_SLAVE_READBACK_EN
                            rd_word <= '0;
`endif
                        end else begin
                            sync_q       <= sync_n;
                            bcast_q      <= bcast_n;
                            buf_q        <= buf_n;
                            dac_q        <= dac_n;
                            dac_update_o <= upd_n;
`ifdef GPA_FHDO_SLAVE_READBACK_EN
                            if (is_rd) rd_word <= {1'b1, 3'b000, addr, rd_val};
`endif
                        end
                    end else begin
                        frame_err_o <= 1'b1;
                    end
                end
                default: state <= ST_ARM;
            endcase
        end
    end

    assign dac_data_o = dac_q;
    assign sync_reg_o = sync_q;
endmodule

// File: tb/tb_gpa_fhdo_dac_spi_slave.sv
// Directed bench for gpa_fhdo_dac_spi_slave: SPI master tasks plus a frame scoreboard.
module tb_gpa_fhdo_dac_spi_slave;
    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b1, csn = 1'b1, sdi = 1'b0;
    logic        sdo;
    logic [63:0] dac_data;
    logic [3:0]  dac_update;
    logic [15:0] sync_reg;
    logic        frame_valid, frame_err;
    logic [23:0] frame_word;

    always #5 clk = ~clk;

    gpa_fhdo_dac_spi_slave dut (
        .clk(clk), .rst_n(rst_n),
        .spi_clk_i(sclk), .spi_csn_i(csn), .spi_sdi_i(sdi), .spi_sdo_o(sdo),
        .dac_data_o(dac_data), .dac_update_o(dac_update), .sync_reg_o(sync_reg),
        .frame_valid_o(frame_valid), .frame_err_o(frame_err), .frame_word_o(frame_word));

    typedef struct {
        logic        err;
        logic [23:0] word;
        logic [63:0] dac;
        logic [3:0]  upd;
        logic [15:0] sync;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0, passed = 0, fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every frame pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_valid || frame_err) begin
                if (q.size() == 0) check("unexpected_frame", 64'd1, 64'd0);
                else begin
                    e = q.pop_front();
                    check("valid", 64'(frame_valid), 64'(!e.err));
                    check("err", 64'(frame_err), 64'(e.err));
                    check("word", 64'(frame_word), 64'(e.word));
                    check("dac", dac_data, e.dac);
                    check("upd", 64'(dac_update), 64'(e.upd));
                    check("sync", 64'(sync_reg), 64'(e.sync));
                end
            end else if (dac_update != 4'b0) begin
                check("stray_upd", 64'(dac_update), 64'd0);
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift(input logic [31:0] w, input int n, output logic [31:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            sdi = w[i];
            clks(HALF);
            rx = {rx[30:0], sdo};
            sclk = 1'b0;
            clks(HALF);
            sclk = 1'b1;
        end
    endtask

    task automatic frame(input logic [31:0] w, input int n, output logic [31:0] rx);
        csn = 1'b0;
        clks(HALF);
        shift(w, n, rx);
        clks(HALF);
        csn = 1'b1;
        clks(3 * HALF);
    endtask

    task automatic send(input logic [31:0] w, input int n, input logic err, input logic [23:0] word,
                        input logic [63:0] dac, input logic [3:0] upd, input logic [15:0] sync);
        logic [31:0] rx;
        exp_t x;
        x.err = err; x.word = word; x.dac = dac; x.upd = upd; x.sync = sync;
        q.push_back(x);
        frame(w, n, rx);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100 && q.size() != 0; i++) clks(1);
        check(tag, 64'(q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clks(3);
        rst_n = 1'b1;
        clks(10);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rx;
        clks(3);
        check("rst_sync", 64'(sync_reg), 64'hFF00);
        check("rst_dac", dac_data, 64'h0);
        check("rst_upd", 64'(dac_update), 64'h0);
        check("rst_valid", 64'(frame_valid), 64'h0);
        check("rst_err", 64'(frame_err), 64'h0);
        check("rst_word", 64'(frame_word), 64'h0);
        check("rst_sdo", 64'(sdo), 64'h0);
        rst_n = 1'b1;
        clks(10);

        // Direct write with sync mode off
        send(32'h020000, 24, 1'b0, 24'h020000, 64'h0, 4'h0, 16'h0000);
        send(32'h0A1234, 24, 1'b0, 24'h0A1234, 64'h0000_1234_0000_0000, 4'b0100, 16'h0000);
        drain("drain_a");

        // Broadcast from reset SYNC value
        do_reset();
        send(32'h06ABCD, 24, 1'b0, 24'h06ABCD, 64'hABCD_ABCD_ABCD_ABCD, 4'b1111, 16'hFF00);

        // Sync mode: buffered write, then LDAC trigger
        send(32'h02000F, 24, 1'b0, 24'h02000F, 64'hABCD_ABCD_ABCD_ABCD, 4'b0000, 16'h000F);
        send(32'h085555, 24, 1'b0, 24'h085555, 64'hABCD_ABCD_ABCD_ABCD, 4'b0000, 16'h000F);
        send(32'h050010, 24, 1'b0, 24'h050010, 64'hABCD_ABCD_ABCD_5555, 4'b0001, 16'h000F);

        // Short and long frames are discarded
        send(32'h091111, 17, 1'b1, 24'h050010, 64'hABCD_ABCD_ABCD_5555, 4'b0000, 16'h000F);
        send(32'h091111 << 2, 26, 1'b1, 24'h050010, 64'hABCD_ABCD_ABCD_5555, 4'b0000, 16'h000F);
        drain("drain_b");

        // Reset mid-frame, frame completes afterwards: must not commit
        csn = 1'b0;
        clks(HALF);
        shift(32'h0B1111, 10, rx);
        rst_n = 1'b0;
        clks(2);
        rst_n = 1'b1;
        clks(2);
        shift(32'h0B1111, 14, rx);
        clks(HALF);
        csn = 1'b1;
        clks(3 * HALF);
        check("midrst_dac", dac_data, 64'h0);
        check("midrst_sync", 64'(sync_reg), 64'hFF00);
        send(32'h0B00FF, 24, 1'b0, 24'h0B00FF, 64'h00FF_0000_0000_0000, 4'b1000, 16'hFF00);

        // Soft reset through TRIGGER
        send(32'h081234, 24, 1'b0, 24'h081234, 64'h00FF_0000_0000_1234, 4'b0001, 16'hFF00);
        send(32'h05000A, 24, 1'b0, 24'h05000A, 64'h0, 4'b0000, 16'hFF00);

        // Read frame is a no-op for the registers; readback appears in the next frame
        send(32'h090042, 24, 1'b0, 24'h090042, 64'h0000_0000_0042_0000, 4'b0010, 16'hFF00);
        send(32'h890000, 24, 1'b0, 24'h890000, 64'h0000_0000_0042_0000, 4'b0000, 16'hFF00);
        begin
            exp_t x;
            x.err = 1'b0; x.word = 24'h000000; x.dac = 64'h0000_0000_0042_0000; x.upd = 4'b0; x.sync = 16'hFF00;
            q.push_back(x);
            frame(32'h000000, 24, rx);
        end
`ifdef GPA_FHDO_SLAVE_READBACK_EN
        check("sdo_stream", 64'(rx[23:0]), 64'h890042);
`else
        check("sdo_stream", 64'(rx[23:0]), 64'h0);
`endif
        check("sdo_idle", 64'(sdo), 64'h0);
        drain("drain_c");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
